// File: rtl/grey_colorize.sv
// grey_colorize: two-stage handshaked grey-to-RGB colouriser with per-frame mode and frame counters
module grey_colorize #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_grey_i,
   input  logic              s_sof_i,
   input  logic              s_last_i,
   input  logic [1:0]        mode_i,
   input  logic [DATA_W-1:0] thresh_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] red_o,
   output logic [DATA_W-1:0] green_o,
   output logic [DATA_W-1:0] blue_o,
   output logic              m_sof_o,
   output logic              m_last_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  pix_cnt_o,
   output logic [CNT_W-1:0]  frame_cnt_o
);
   logic              en;
   logic              hs_in;
   logic              hs_out;
   logic [1:0]        mode_r;
   logic [DATA_W-1:0] thresh_r;
   logic [1:0]        mode_eff;
   logic [DATA_W-1:0] thresh_eff;
   logic              v1;
   logic [DATA_W-1:0] g1;
   logic [DATA_W-1:0] th1;
   logic [1:0]        mode1;
   logic              sof1;
   logic              last1;
   logic [DATA_W-1:0] dbl;
   logic [DATA_W-1:0] lvl;
   logic              hot;
   logic [DATA_W-1:0] r_n;
   logic [DATA_W-1:0] g_n;
   logic [DATA_W-1:0] b_n;

   // the whole pipeline moves as one: it advances whenever the output slot is free or being drained
   assign en         = ~m_valid_o | m_ready_i;
   assign s_ready_o  = en & ~sys_rst_i;
   assign hs_in      = s_valid_i & s_ready_o;
   assign hs_out     = m_valid_o & m_ready_i;
   assign done_o     = hs_out & m_last_o;
   // a sof beat uses the mode/threshold presented with it; later beats use the latched frame values
   assign mode_eff   = s_sof_i ? mode_i : mode_r;
   assign thresh_eff = s_sof_i ? thresh_i : thresh_r;

   // frame registers: capture mode and threshold on an accepted start-of-frame beat
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         mode_r   <= '0;
         thresh_r <= '0;
      end else if (hs_in & s_sof_i) begin
         mode_r   <= mode_i;
         thresh_r <= thresh_i;
      end
   end

   // stage 1: register the grey pixel, framing flags and the effective mode/threshold
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         v1    <= 1'b0;
         g1    <= '0;
         th1   <= '0;
         mode1 <= '0;
         sof1  <= 1'b0;
         last1 <= 1'b0;
      end else if (en) begin
         v1    <= s_valid_i;
         g1    <= s_grey_i;
         th1   <= thresh_eff;
         mode1 <= mode_eff;
         sof1  <= s_sof_i;
         last1 <= s_last_i;
      end
   end

   // colour mapping; heatmap uses 2g (low half) or 2(g-HALF) (high half), both equal to g shifted left
   always_comb begin
      dbl = {g1[DATA_W-2:0], 1'b0};
      lvl = mode1[1] ? {DATA_W{g1 >= th1}} : (mode1[0] ? ~g1 : g1);
      hot = mode1 == 2'd3;
      r_n = hot ? (g1[DATA_W-1] ? dbl : '0) : lvl;
      g_n = hot ? (g1[DATA_W-1] ? ~dbl : dbl) : lvl;
      b_n = hot ? (g1[DATA_W-1] ? '0 : ~dbl) : lvl;
   end

   // stage 2: register the RGB result and the framing flags travelling with it
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         m_valid_o <= 1'b0;
         red_o     <= '0;
         green_o   <= '0;
         blue_o    <= '0;
         m_sof_o   <= 1'b0;
         m_last_o  <= 1'b0;
      end else if (en) begin
         m_valid_o <= v1;
         red_o     <= r_n;
         green_o   <= g_n;
         blue_o    <= b_n;
         m_sof_o   <= sof1;
         m_last_o  <= last1;
      end
   end

   // output-side counters: pixels in the current frame (saturating) and completed frames (wrapping)
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         pix_cnt_o   <= '0;
         frame_cnt_o <= '0;
      end else begin
         if (hs_out)
            pix_cnt_o <= m_sof_o ? CNT_W'(1) : (&pix_cnt_o ? pix_cnt_o : pix_cnt_o + CNT_W'(1));
         if (done_o)
            frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_grey_colorize.sv
// tb_grey_colorize: scoreboard bench for grey_colorize with a behavioural colour/counter model
module tb_grey_colorize;
   localparam int DW   = 8;
   localparam int CW   = 5;
   localparam int MAXV = 255;
   localparam int HALF = 128;
   localparam int CMAX = 31;

   typedef struct packed {
      logic [DW-1:0] r;
      logic [DW-1:0] g;
      logic [DW-1:0] b;
      logic          sof;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_grey = '0;
   logic          s_sof = 1'b0;
   logic          s_last = 1'b0;
   logic [1:0]    mode = '0;
   logic [DW-1:0] thresh = '0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] red;
   logic [DW-1:0] green;
   logic [DW-1:0] blue;
   logic          m_sof;
   logic          m_last;
   logic          done;
   logic [CW-1:0] pix_cnt;
   logic [CW-1:0] frame_cnt;

   beat_t q[$];
   int n_chk = 0;
   int n_pass = 0;
   int mode_m = 0;
   int th_m = 0;
   int exp_pix = 0;
   int exp_frame = 0;
   int bp_mode = 0;
   int done_seen = 0;

   always #5 clk = ~clk;

   grey_colorize #(.DATA_W(DW), .CNT_W(CW)) dut (
      .sys_clk_i(clk), .sys_rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
      .s_grey_i(s_grey), .s_sof_i(s_sof), .s_last_i(s_last), .mode_i(mode),
      .thresh_i(thresh), .m_valid_o(m_valid), .m_ready_i(m_ready), .red_o(red),
      .green_o(green), .blue_o(blue), .m_sof_o(m_sof), .m_last_o(m_last),
      .done_o(done), .pix_cnt_o(pix_cnt), .frame_cnt_o(frame_cnt)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic beat_t model(input int g, input bit sof, input bit last);
      beat_t b;
      int v;
      int d;
      v = 0;
      if (mode_m == 0) v = g;
      else if (mode_m == 1) v = MAXV - g;
      else if (mode_m == 2) v = (g >= th_m) ? MAXV : 0;
      b.sof = sof;
      b.last = last;
      if (mode_m == 3) begin
         if (g < HALF) begin
            b.r = 0; b.g = DW'(2 * g); b.b = DW'(MAXV - 2 * g);
         end else begin
            d = g - HALF;
            b.r = DW'(2 * d); b.g = DW'(MAXV - 2 * d); b.b = 0;
         end
      end else begin
         b.r = DW'(v); b.g = DW'(v); b.b = DW'(v);
      end
      return b;
   endfunction

   task automatic send(input int g, input bit sof, input bit last, input int md, input int th);
      int t;
      t = 0;
      s_valid = 1'b1; s_grey = DW'(g); s_sof = sof; s_last = last;
      mode = 2'(md); thresh = DW'(th);
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 300) begin
            n_chk++;
            $display("FAIL send_timeout: beat %0h never accepted", g);
            break;
         end
      end
      if (sof) begin mode_m = md; th_m = th; end
      q.push_back(model(g, sof, last));
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 400) begin @(posedge clk); t++; end
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d beats still expected, 0 required", q.size());
         q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // downstream ready: always, random, or held low
   initial forever begin
      @(posedge clk); #1;
      m_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
   end

   // monitor: compares every output beat with the scoreboard and checks stalls and counters
   logic [DW-1:0] hr, hg, hb;
   logic hsf, hl;
   logic stall_prev = 1'b0;
   initial forever begin
      beat_t e;
      @(negedge clk);
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         chk("pix_cnt", pix_cnt, exp_pix);
         chk("frame_cnt", frame_cnt, exp_frame);
         chk("s_ready", s_ready, (!m_valid || m_ready) ? 1 : 0);
         chk("done", done, (m_valid && m_ready && m_last) ? 1 : 0);
         if (done) done_seen++;
         if (stall_prev) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_red", red, hr);
            chk("stall_green", green, hg);
            chk("stall_blue", blue, hb);
            chk("stall_sof", m_sof, hsf);
            chk("stall_last", m_last, hl);
         end
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL extra_beat: got rgb %0h/%0h/%0h, none expected", red, green, blue);
            end else begin
               e = q.pop_front();
               chk("red", red, e.r);
               chk("green", green, e.g);
               chk("blue", blue, e.b);
               chk("m_sof", m_sof, e.sof);
               chk("m_last", m_last, e.last);
               exp_pix = e.sof ? 1 : (exp_pix < CMAX ? exp_pix + 1 : CMAX);
               if (e.last) exp_frame = (exp_frame + 1) % (CMAX + 1);
            end
         end
         stall_prev = m_valid && !m_ready;
         hr = red; hg = green; hb = blue; hsf = m_sof; hl = m_last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      bit drop_last;
      int md;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_red", red, 0);
      chk("rst_blue", blue, 0);
      chk("rst_done", done, 0);
      chk("rst_pix", pix_cnt, 0);
      chk("rst_frame", frame_cnt, 0);
      @(negedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;

      // replicate, single-pixel frame, latency of two cycles
      send(8'h5A, 1, 1, 0, 0);
      @(negedge clk);
      chk("lat_cycle1_valid", m_valid, 0);
      @(negedge clk);
      chk("lat_cycle2_valid", m_valid, 1);
      chk("lat_red", red, 8'h5A);
      chk("lat_green", green, 8'h5A);
      chk("lat_sof", m_sof, 1);
      drain();
      chk("one_pix_frame_pix", pix_cnt, 1);
      chk("one_pix_frame_cnt", frame_cnt, 1);

      // invert, 4-pixel frame
      done_seen = 0;
      send(8'h00, 1, 0, 1, 0);
      send(8'h7F, 0, 0, 0, 0);
      send(8'h80, 0, 0, 2, 0);
      send(8'hFF, 0, 1, 3, 0);
      drain();
      chk("inv_done_pulses", done_seen, 1);
      chk("inv_pix", pix_cnt, 4);
      chk("inv_frame", frame_cnt, 2);

      // threshold, inclusive compare, mid-frame threshold change ignored
      send(8'h7F, 1, 0, 2, 8'h80);
      send(8'h80, 0, 0, 2, 8'h10);
      send(8'h81, 0, 0, 2, 8'h10);
      send(8'h20, 0, 1, 2, 8'h10);
      send(8'h20, 1, 1, 2, 8'h10);
      drain();

      // heatmap endpoints
      send(8'h00, 1, 0, 3, 0);
      send(8'h7F, 0, 0, 3, 0);
      send(8'h80, 0, 0, 3, 0);
      send(8'hFF, 0, 1, 3, 0);
      drain();

      // 16-pixel frame with downstream held off for 5 cycles mid-stream
      fork
         for (int i = 0; i < 16; i++) send($urandom_range(0, 255), i == 0, i == 15, 0, 0);
         begin
            repeat (6) @(posedge clk);
            bp_mode = 2;
            repeat (5) @(posedge clk);
            bp_mode = 0;
         end
      join
      drain();
      chk("bp_pix16", pix_cnt, 16);

      // pixel counter saturation with random backpressure
      bp_mode = 1;
      for (int i = 0; i < 40; i++) send($urandom_range(0, 255), i == 0, i == 39, $urandom_range(0, 3), 0);
      drain();
      chk("sat_pix", pix_cnt, CMAX);

      // random frames; some lack a last, mode/threshold wiggle mid-frame
      for (int f = 0; f < 60; f++) begin
         len = $urandom_range(1, 12);
         drop_last = ($urandom_range(0, 9) == 0);
         md = $urandom_range(0, 3);
         for (int i = 0; i < len; i++) begin
            send($urandom_range(0, 255), i == 0, (i == len - 1) && !drop_last,
                 (i == 0) ? md : $urandom_range(0, 3), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      drain();

      // asynchronous reset in the middle of a frame
      for (int i = 0; i < 5; i++) send($urandom_range(0, 255), i == 0, 0, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_s_ready", s_ready, 0);
      chk("arst_red", red, 0);
      chk("arst_green", green, 0);
      chk("arst_blue", blue, 0);
      chk("arst_sof", m_sof, 0);
      chk("arst_last", m_last, 0);
      chk("arst_done", done, 0);
      chk("arst_pix", pix_cnt, 0);
      chk("arst_frame", frame_cnt, 0);
      q.delete();
      mode_m = 0; th_m = 0; exp_pix = 0; exp_frame = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      send(8'h33, 0, 0, 2, 8'h40);
      send(8'h10, 1, 0, 1, 0);
      send(8'h20, 0, 0, 0, 0);
      send(8'h30, 0, 1, 0, 0);
      drain();
      chk("post_rst_frame", frame_cnt, 1);
      chk("post_rst_pix", pix_cnt, 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/grey_colorize.md
Name: grey_colorize

Overview:
- Parametrised, handshaked successor of the grey-to-RGB expander.
- Takes a grey pixel stream from the Sobel/greyscale path and produces an RGB pixel stream.
- Colour mode is selectable per frame: replicate, invert, binary threshold or heatmap false-colour.
- Two-stage pipeline with valid/ready backpressure, start-of-frame and end-of-frame framing, and a frame-complete pulse and counters for the display/DMA sink.

Parameters:
DATA_W, 8, bit width of the grey input and of each colour channel output (minimum 2)
CNT_W, 16, width of the pixel counter and the frame counter

Ports:
sys_clk_i  in  1  system clock, rising edge
sys_rst_i  in  1  asynchronous active-high reset
s_valid_i  in  1  input beat valid
s_ready_o  out  1  input beat accepted when s_valid_i & s_ready_o
s_grey_i  in  DATA_W  grey pixel
s_sof_i  in  1  first pixel of frame
s_last_i  in  1  last pixel of frame
mode_i  in  2  colour mode: 0 replicate, 1 invert, 2 threshold, 3 heatmap
thresh_i  in  DATA_W  threshold level for mode 2
m_valid_o  out  1  output beat valid
m_ready_i  in  1  downstream ready
red_o  out  DATA_W  red channel
green_o  out  DATA_W  green channel
blue_o  out  DATA_W  blue channel
m_sof_o  out  1  sof aligned with the output beat
m_last_o  out  1  last aligned with the output beat
done_o  out  1  one-cycle frame-complete pulse
pix_cnt_o  out  CNT_W  pixels output in the current frame
frame_cnt_o  out  CNT_W  completed frames

Behaviour:
- Reset: async assert of sys_rst_i clears all registers. While reset is high, all outputs are 0, including s_ready_o. Reset mid-frame discards in-flight beats; the first beat after reset without s_sof_i is processed with mode 0.
- Pipeline: stage 1 registers grey/sof/last plus the effective mode and threshold. Stage 2 registers the RGB result and flags. Each stage has its own valid bit.
- Enable: en = ~m_valid_o | m_ready_i. Both stages advance only when en = 1.
- s_ready_o = en & ~sys_rst_i (combinational from m_ready_i; no bubble insertion).
- Latency: an accepted beat appears on the outputs exactly 2 cycles later with no backpressure. Sustained throughput is 1 beat/cycle.
- Stall: while m_valid_o & ~m_ready_i, all outputs hold stable and no input is accepted.
- Mode/threshold capture: mode_i and thresh_i are latched into frame registers on an accepted beat with s_sof_i = 1, and apply from that beat on. Changes mid-frame are ignored until the next sof.
- MAX = 2^DATA_W - 1; HALF = 2^(DATA_W-1).
- Mode 0 (replicate): R = G = B = g.
- Mode 1 (invert): R = G = B = MAX - g.
- Mode 2 (threshold): if g >= thresh, R = G = B = MAX; otherwise all 0. The comparison is inclusive.
- Mode 3 (heatmap):
  - g < HALF: R = 0, G = 2g, B = MAX - 2g.
  - g >= HALF: let d = g - HALF; R = 2d, G = MAX - 2d, B = 0.
  - All results fit in DATA_W bits; no saturation is needed.
- Flags: m_sof_o and m_last_o travel with the pixel and are valid only while m_valid_o = 1.
- done_o: high for exactly one cycle when m_valid_o & m_ready_i & m_last_o.
- pix_cnt_o:
  - On an output handshake with m_sof_o, loads 1.
  - Otherwise increments on each output handshake.
  - Saturates at 2^CNT_W - 1.
  - Holds after last until the next sof.
- frame_cnt_o: increments on each done_o pulse and wraps to 0 after 2^CNT_W - 1.
- Framing errors: a beat with both sof and last is a 1-pixel frame; done_o fires and pix_cnt_o = 1. A sof arriving with no prior last just restarts pix_cnt_o; frame_cnt_o is unchanged.

Test Plan:
- Mode 0, sof, grey 0x5A, m_ready_i = 1 -> two cycles later RGB = 5A/5A/5A, m_valid_o = 1, m_sof_o = 1.
- Mode 1, 4-pixel frame 00, 7F, 80, FF -> RGB values FF, 80, 7F, 00. On the last beat: done_o pulses once, pix_cnt_o = 4, frame_cnt_o increments by 1.
- Mode 2, thresh 0x80, grey 7F/80/81 -> 00/FF/FF on all channels. thresh_i changed to 0x10 mid-frame -> no effect until the next sof.
- Mode 3, grey 00, 7F, 80, FF -> (00,00,FF), (00,FE,01), (00,FF,00), (FE,01,00).
- Backpressure: m_ready_i held low for 5 cycles with a stream in flight -> s_ready_o = 0 and outputs stable throughout. On release, no beat is lost or duplicated, ordering is preserved, and a 16-pixel frame yields pix_cnt_o = 16.
- Reset asserted asynchronously mid-frame (between clock edges) -> outputs go to 0 immediately. After release, a new sof frame processes correctly and frame_cnt_o restarts from 0.
